// File: rtl/nios_system_cam_pio_in.sv
// Avalon-MM input port for camera status lines: synchronised live value,
// per-bit edge capture (W1C), maskable level interrupt and a snapshot register.
module nios_system_cam_pio_in #(
    parameter int WIDTH       = 15,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int              PW         = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0]   PRIME_LOAD = PW'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] snapshot;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] clr;
    logic [PW-1:0]    prime_cnt;
    logic [31:0]      rd_next;
    logic             wr;
    logic             unused_wdata;

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        return 32'(v);
    endfunction

    assign data         = sync_p[SYNC_STAGES-1];
    assign wr           = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    // Edge events are suppressed until the synchroniser and prev have settled
    // after reset, so lines held high through reset do not look like edges.
    always_comb begin
        evt = '0;
        case (EDGE_TYPE)
            0:       evt = data & ~prev;
            1:       evt = ~data & prev;
            default: evt = data ^ prev;
        endcase
        if (prime_cnt != '0) evt = '0;
    end

    always_comb begin
        clr = '0;
        if (wr && address == 2'd2) clr = writedata[WIDTH-1:0];
    end

    always_comb begin
        rd_next = '0;
        case (address)
            2'd0: rd_next = zext(data);
            2'd1: rd_next = zext(irq_mask);
            2'd2: rd_next = zext(edge_cap);
            2'd3: rd_next = zext(snapshot);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
            prev      <= '0;
            irq_mask  <= '0;
            edge_cap  <= '0;
            snapshot  <= '0;
            prime_cnt <= PRIME_LOAD;
            readdata  <= '0;
            irq       <= 1'b0;
        end else begin
            sync_p[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
            prev <= data;
            if (prime_cnt != '0) prime_cnt <= prime_cnt - PW'(1);
            // A new event wins over a same-cycle clear.
            edge_cap <= (edge_cap & ~clr) | evt;
            if (wr && address == 2'd1) irq_mask <= writedata[WIDTH-1:0];
            if (wr && address == 2'd3) snapshot <= data;
            irq      <= |(edge_cap & irq_mask);
            readdata <= rd_next;
        end
    end

endmodule
